key_scan4x4: RTL



---
 rtl/key_scan4x4_if.sv | 20 ++
 rtl/key_scan4x4.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/key_scan4x4_if.sv
// rtl/key_scan4x4_if.sv - keypad pins and decoded key stream of key_scan4x4
interface key_scan4x4_if;
   logic [3:0]  row_i;
   logic        clr_i;
   logic [3:0]  col_o;
   logic        key_valid_o;
   logic [3:0]  key_code_o;
   logic        key_held_o;
   logic [31:0] entry_o;

   modport master (
      input  row_i, clr_i,
      output col_o, key_valid_o, key_code_o, key_held_o, entry_o
   );

   modport slave (
      output row_i, clr_i,
      input  col_o, key_valid_o, key_code_o, key_held_o, entry_o
   );
endinterface

// File: rtl/key_scan4x4.sv
// rtl/key_scan4x4.sv - 4x4 keypad scanner, debouncer and hex entry register
// Optional held-key auto-repeat is built when KEY_AUTOREPEAT_EN is defined.
module key_scan4x4 #(
   parameter int SCAN_DIV     = 16,
   parameter int DEBOUNCE_N   = 4,
   parameter int REPEAT_TICKS = 32
) (
   input  logic          clk,
   input  logic          rstn,
   key_scan4x4_if.master kp
);
   typedef enum logic [1:0] {SCAN, PRESS_DB, HELD, REL_DB} state_t;

   localparam logic [3:0] DB_N = 4'(DEBOUNCE_N);

   state_t              state, state_n;
   logic [SCAN_DIV-1:0] tick_cnt;
   logic                tick;
   logic [3:0]          row_meta, rs;
   logic [1:0]          col_idx, col_idx_n;
   logic [1:0]          row_q, row_n, low_row;
   logic [3:0]          db_cnt, db_cnt_n;
   logic                shift;
   logic [3:0]          code_n;
   logic                key_valid_q;
   logic [3:0]          key_code_q;
   logic [31:0]         entry_q;
`ifdef KEY_AUTOREPEAT_EN
   localparam int               REP_W = $clog2(REPEAT_TICKS + 1);
   localparam logic [REP_W-1:0] REP_N = REP_W'(REPEAT_TICKS);
   logic [REP_W-1:0]            rep_cnt, rep_cnt_n;
`endif

   assign tick = &tick_cnt;

   always_comb begin
      low_row = 2'd0;
      if (!rs[0])      low_row = 2'd0;
      else if (!rs[1]) low_row = 2'd1;
      else if (!rs[2]) low_row = 2'd2;
      else if (!rs[3]) low_row = 2'd3;
   end

   always_comb begin
      state_n   = state;
      col_idx_n = col_idx;
      row_n     = row_q;
      db_cnt_n  = db_cnt;
      shift     = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rep_cnt_n = rep_cnt;
`endif
      if (tick) begin
         case (state)
            SCAN: begin
               if (rs != 4'hF) begin
                  row_n    = low_row;
                  db_cnt_n = 4'd1;
                  state_n  = PRESS_DB;
                  if (DB_N == 4'd1) begin
                     shift    = 1'b1;
                     db_cnt_n = 4'd0;
                     state_n  = HELD;
`ifdef KEY_AUTOREPEAT_EN
                     rep_cnt_n = '0;
`endif
                  end
               end else begin
                  col_idx_n = col_idx + 2'd1;
               end
            end
            PRESS_DB: begin
               if (!rs[row_q]) begin
                  db_cnt_n = db_cnt + 4'd1;
                  if (db_cnt + 4'd1 == DB_N) begin
                     shift    = 1'b1;
                     db_cnt_n = 4'd0;
                     state_n  = HELD;
`ifdef KEY_AUTOREPEAT_EN
                     rep_cnt_n = '0;
`endif
                  end
               end else begin
                  db_cnt_n = 4'd0;
                  state_n  = SCAN;
               end
            end
            HELD: begin
               if (rs == 4'hF) begin
                  db_cnt_n = 4'd1;
                  state_n  = REL_DB;
                  if (DB_N == 4'd1) begin
                     db_cnt_n  = 4'd0;
                     state_n   = SCAN;
                     col_idx_n = col_idx + 2'd1;
                  end
               end
`ifdef KEY_AUTOREPEAT_EN
               else if (rep_cnt + 1'b1 == REP_N) begin
                  shift     = 1'b1;
                  rep_cnt_n = '0;
               end else begin
                  rep_cnt_n = rep_cnt + 1'b1;
               end
`endif
            end
            REL_DB: begin
               if (rs == 4'hF) begin
                  if (db_cnt + 4'd1 == DB_N) begin
                     db_cnt_n  = 4'd0;
                     state_n   = SCAN;
                     col_idx_n = col_idx + 2'd1;
                  end else begin
                     db_cnt_n = db_cnt + 4'd1;
                  end
               end else begin
                  // a bounce during release resumes holding without a new press
                  db_cnt_n = 4'd0;
                  state_n  = HELD;
`ifdef KEY_AUTOREPEAT_EN
                  rep_cnt_n = '0;
`endif
               end
            end
            default: state_n = SCAN;
         endcase
      end
      code_n = {row_n, col_idx};
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         row_meta    <= 4'hF;
         rs          <= 4'hF;
         tick_cnt    <= '0;
         state       <= SCAN;
         col_idx     <= 2'd0;
         row_q       <= 2'd0;
         db_cnt      <= 4'd0;
         key_valid_q <= 1'b0;
         key_code_q  <= 4'd0;
         entry_q     <= 32'h0;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt     <= '0;
`endif
      end else begin
         row_meta    <= kp.row_i;
         rs          <= row_meta;
         tick_cnt    <= tick_cnt + SCAN_DIV'(1);
         state       <= state_n;
         col_idx     <= col_idx_n;
         row_q       <= row_n;
         db_cnt      <= db_cnt_n;
         key_valid_q <= shift;
`ifdef KEY_AUTOREPEAT_EN
         rep_cnt     <= rep_cnt_n;
`endif
         if (shift) begin
            key_code_q <= code_n;
            // clear and shift together act as clear-then-shift
            entry_q    <= {(kp.clr_i ? 28'h0 : entry_q[27:0]), code_n};
         end else if (kp.clr_i) begin
            entry_q <= 32'h0;
         end
      end
   end

   assign kp.col_o       = ~(4'b0001 << col_idx);
   assign kp.key_valid_o = key_valid_q;
   assign kp.key_code_o  = key_code_q;
   assign kp.key_held_o  = (state == HELD) || (state == REL_DB);
   assign kp.entry_o     = entry_q;
endmodule
